vending_ctrl: RTL
=================

VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NPROD, 4, number of products.
- SELW, 2, product index width (>= clog2(NPROD)).
- CW, 8, credit/price width.
- PRICES, {8'd20,8'd15,8'd10,8'd5}, packed prices; product i occupies bits [i*CW +: CW].
- COIN_VALS, {8'd50,8'd20,8'd10,8'd5}, packed values of coin types 0..3, same packing.
- MAX_CREDIT, 50, credit ceiling.
- SW, 3, per-product stock counter width.
- STOCK_INIT, 7, stock loaded at reset and on restock.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- coin_valid, in, 1, a coin is present this cycle.
- coin_type, in, 2, coin denomination index.
- sel_valid, in, 1, a product selection is present this cycle.
- sel, in, SELW, selected product index.
- cancel, in, 1, refund request.
- restock, in, 1, reload all stock counters.
- vend_valid, out, 1, one-cycle dispense pulse.
- vend_id, out, SELW, product dispensed.
- change_valid, out, 1, one-cycle change pulse.
- change_amt, out, CW, change value.
- coin_reject, out, 1, one-cycle coin-return pulse.
- sel_deny, out, 1, one-cycle selection-refused pulse.
- sold_out, out, NPROD, bit i high when stock[i] == 0.
- credit, out, CW, current credit.
- busy, out, 1, high in VEND or CHANGE.

Function
REQ-003 The FSM SHALL have four states: IDLE (credit == 0), CREDIT (credit > 0), VEND and CHANGE.
REQ-004 In IDLE or CREDIT, an accepted coin SHALL add its COIN_VALS value to credit, visible the next cycle; the state SHALL then be CREDIT.
REQ-005 A coin SHALL be rejected (coin_reject = 1 the next cycle, credit unchanged) when credit + value > MAX_CREDIT, or when it arrives in VEND or CHANGE.
REQ-006 Any arithmetic SHALL be computed at CW+1 bits so that overflow cannot wrap.
REQ-007 In CREDIT, a selection with sel < NPROD, stock[sel] > 0 and credit >= price[sel] SHALL cause, on the next cycle: state VEND, vend_valid = 1, vend_id = sel, credit -= price, stock[sel] -= 1.
REQ-008 Any other selection SHALL produce sel_deny = 1 for one cycle with no other state change; this includes a selection in IDLE, VEND or CHANGE.
REQ-009 VEND SHALL last exactly one cycle and then go to CHANGE.
REQ-010 CHANGE SHALL last exactly one cycle, then go to IDLE with credit = 0:
- If the residual credit is > 0: change_valid = 1 and change_amt = residual credit.
- Otherwise: change_valid = 0.
REQ-011 cancel in CREDIT SHALL go to CHANGE on the next cycle with the full credit as change; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-012 When events coincide in CREDIT, priority SHALL be cancel > selection > coin; the losing coin SHALL be rejected, and the losing selection SHALL be denied.
REQ-013 restock SHALL set every stock counter to STOCK_INIT in any state, overriding a same-cycle decrement.
REQ-014 change_amt SHALL be 0 whenever change_valid = 0, and vend_id SHALL be 0 whenever vend_valid = 0.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 When rst_n = 0, the block SHALL immediately force:
- state to IDLE and credit to 0;
- all pulse outputs to 0, change_amt to 0 and vend_id to 0;
- every stock counter to STOCK_INIT, so sold_out = 0.
REQ-017 A reset during VEND or CHANGE SHALL discard pending change; no pulse SHALL be issued after rst_n rises.

Verification
REQ-018 Coin 10 (type 1), then sel 0 -> vend_valid with vend_id 0, then change_valid with change_amt 5, credit 0, state IDLE.
REQ-019 Coins 20, 20, 10, then coin 5 -> the coin 5 is rejected (coin_reject = 1) and credit stays 50.
REQ-020 Coin 10, then sel 3 -> sel_deny = 1 and credit stays 10; then cancel -> change_amt 10.
REQ-021 Vend product 1 seven times -> sold_out[1] = 1 and an eighth selection is denied; then restock -> sold_out = 0.
REQ-022 In CREDIT, cancel, sel_valid and coin_valid in the same cycle -> change of the prior credit, coin_reject = 1 and sel_deny = 1.
REQ-023 Assert rst_n = 0 during VEND -> outputs clear asynchronously and no change_valid pulse follows.

Source files
------------

// File: rtl/vending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vending_ctrl
//  Description : Coin-operated vending controller. Accumulates coin credit up
//                to a ceiling, dispenses a product when a selection is
//                affordable and in stock, and returns the residual credit as
//                change one cycle after the dispense cycle. Cancel refunds
//                the whole credit. Per-product stock counters are reloaded by
//                restock.
//
//  Ports       : clk          - clock, all state changes on rising edge
//                rst_n        - asynchronous active-low reset
//                coin_valid   - coin present this cycle
//                coin_type    - coin denomination index (0..3)
//                sel_valid    - product selection present this cycle
//                sel          - selected product index
//                cancel       - refund request
//                restock      - reload every stock counter
//                vend_valid   - one-cycle dispense pulse
//                vend_id      - product dispensed (0 when no dispense)
//                change_valid - one-cycle change pulse
//                change_amt   - change value (0 when no change)
//                coin_reject  - one-cycle coin-return pulse
//                sel_deny     - one-cycle selection-refused pulse
//                sold_out     - bit i high when product i has no stock
//                credit       - current credit
//                busy         - high while dispensing or returning change
//
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_ctrl #(
  parameter int                  NPROD      = 4,
  parameter int                  SELW       = 2,
  parameter int                  CW         = 8,
  parameter logic [NPROD*CW-1:0] PRICES     = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter logic [4*CW-1:0]     COIN_VALS  = {8'd50, 8'd20, 8'd10, 8'd5},
  parameter int                  MAX_CREDIT = 50,
  parameter int                  SW         = 3,
  parameter int                  STOCK_INIT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             sel_valid,
  input  logic [SELW-1:0]  sel,
  input  logic             cancel,
  input  logic             restock,
  output logic             vend_valid,
  output logic [SELW-1:0]  vend_id,
  output logic             change_valid,
  output logic [CW-1:0]    change_amt,
  output logic             coin_reject,
  output logic             sel_deny,
  output logic [NPROD-1:0] sold_out,
  output logic [CW-1:0]    credit,
  output logic             busy
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam logic [CW:0]      c_max_credit = (CW+1)'(MAX_CREDIT);
  localparam logic [SW-1:0]    c_stock_init = SW'(STOCK_INIT);
  localparam logic [NPROD-1:0] c_sold_init  = {NPROD{(c_stock_init == '0)}};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]                r_state;
  logic [CW-1:0]             r_credit;
  logic [NPROD-1:0][SW-1:0]  r_stock;
  logic                      r_vend_valid;
  logic [SELW-1:0]           r_vend_id;
  logic                      r_change_valid;
  logic [CW-1:0]             r_change_amt;
  logic                      r_coin_reject;
  logic                      r_sel_deny;
  logic [NPROD-1:0]          r_sold_out;
  logic                      r_busy;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic [1:0]                w_state_nxt;
  logic [CW-1:0]             w_credit_nxt;
  logic [NPROD-1:0][SW-1:0]  w_stock_nxt;
  logic                      w_vend_valid;
  logic [SELW-1:0]           w_vend_id;
  logic                      w_change_valid;
  logic [CW-1:0]             w_change_amt;
  logic                      w_coin_reject;
  logic                      w_sel_deny;
  logic [NPROD-1:0]          w_sold_nxt;

  // Lookups and arithmetic helpers
  logic [CW-1:0]             w_coin_val;
  logic [CW-1:0]             w_price;
  logic [SW-1:0]             w_stock_sel;
  logic                      w_sel_in_range;
  logic [CW:0]               w_sum;
  logic [CW:0]               w_diff;
  logic                      w_coin_fits;
  logic                      w_can_vend;

  // Coin value and product price/stock lookups. Loops against constant
  // indices avoid out-of-range dynamic part-selects when 2**SELW > NPROD.
  always_comb begin
    w_coin_val     = '0;
    w_price        = '0;
    w_stock_sel    = '0;
    w_sel_in_range = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (coin_type == 2'(i)) begin
        w_coin_val = COIN_VALS[i*CW +: CW];
      end
    end
    for (int i = 0; i < NPROD; i++) begin
      if (sel == SELW'(i)) begin
        w_sel_in_range = 1'b1;
        w_price        = PRICES[i*CW +: CW];
        w_stock_sel    = r_stock[i];
      end
    end
  end

  // One extra bit on sum/difference so a large coin cannot wrap past the
  // ceiling and be mistaken for an acceptable one.
  always_comb begin
    w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_diff      = {1'b0, r_credit} - {1'b0, w_price};
    w_coin_fits = (w_sum <= c_max_credit);
    w_can_vend  = w_sel_in_range && (w_stock_sel != '0) &&
                  ({1'b0, r_credit} >= {1'b0, w_price});
  end

  // --------------------------------------------------------------------------
  // Main next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_stock_nxt    = r_stock;
    w_vend_valid   = 1'b0;
    w_vend_id      = '0;
    w_change_valid = 1'b0;
    w_change_amt   = '0;
    w_coin_reject  = 1'b0;
    w_sel_deny     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // No credit yet: every selection is refused, coins may be taken.
        w_sel_deny = sel_valid;
        if (coin_valid) begin
          if (w_coin_fits) begin
            w_credit_nxt = w_sum[CW-1:0];
            // A zero-valued coin type must not leave IDLE with zero credit.
            w_state_nxt  = (w_sum != '0) ? S_CREDIT : S_IDLE;
          end else begin
            w_coin_reject = 1'b1;
          end
        end
      end

      S_CREDIT: begin
        // Priority cancel > selection > coin; lower-priority events lose.
        if (cancel) begin
          w_state_nxt   = S_CHANGE;
          w_sel_deny    = sel_valid;
          w_coin_reject = coin_valid;
        end else if (sel_valid) begin
          w_coin_reject = coin_valid;
          if (w_can_vend) begin
            w_state_nxt  = S_VEND;
            w_vend_valid = 1'b1;
            w_vend_id    = sel;
            w_credit_nxt = w_diff[CW-1:0];
            for (int i = 0; i < NPROD; i++) begin
              if (sel == SELW'(i)) begin
                w_stock_nxt[i] = r_stock[i] - SW'(1);
              end
            end
          end else begin
            w_sel_deny = 1'b1;
          end
        end else if (coin_valid) begin
          if (w_coin_fits) begin
            w_credit_nxt = w_sum[CW-1:0];
          end else begin
            w_coin_reject = 1'b1;
          end
        end
      end

      S_VEND: begin
        w_state_nxt   = S_CHANGE;
        w_sel_deny    = sel_valid;
        w_coin_reject = coin_valid;
      end

      S_CHANGE: begin
        // The change pulse is issued on leaving CHANGE, so a reset taken
        // while in CHANGE discards it.
        w_state_nxt    = S_IDLE;
        w_credit_nxt   = '0;
        w_change_valid = (r_credit != '0);
        w_change_amt   = r_credit;
        w_sel_deny     = sel_valid;
        w_coin_reject  = coin_valid;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = '0;
      end
    endcase

    // Restock wins over a same-cycle dispense decrement.
    if (restock) begin
      w_stock_nxt = {NPROD{c_stock_init}};
    end
  end

  always_comb begin
    w_sold_nxt = '0;
    for (int i = 0; i < NPROD; i++) begin
      w_sold_nxt[i] = (w_stock_nxt[i] == '0);
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_stock        <= {NPROD{c_stock_init}};
      r_vend_valid   <= 1'b0;
      r_vend_id      <= '0;
      r_change_valid <= 1'b0;
      r_change_amt   <= '0;
      r_coin_reject  <= 1'b0;
      r_sel_deny     <= 1'b0;
      r_sold_out     <= c_sold_init;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_stock        <= w_stock_nxt;
      r_vend_valid   <= w_vend_valid;
      r_vend_id      <= w_vend_id;
      r_change_valid <= w_change_valid;
      r_change_amt   <= w_change_amt;
      r_coin_reject  <= w_coin_reject;
      r_sel_deny     <= w_sel_deny;
      r_sold_out     <= w_sold_nxt;
      r_busy         <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all driven straight from flops)
  // --------------------------------------------------------------------------
  assign vend_valid   = r_vend_valid;
  assign vend_id      = r_vend_id;
  assign change_valid = r_change_valid;
  assign change_amt   = r_change_amt;
  assign coin_reject  = r_coin_reject;
  assign sel_deny     = r_sel_deny;
  assign sold_out     = r_sold_out;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule
`default_nettype wire
